// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state type and line constants for the UART transmitter
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - CPU write strobe and serial/status signals of the UART transmitter
interface uart_tx_fifo_if;

    logic        wr_en;
    logic [31:0] wr_data;
    logic        txd;
    logic        busy;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overflow;

    modport master (
        output wr_en,
        output wr_data,
        input  txd,
        input  busy,
        input  fifo_full,
        input  fifo_empty,
        input  overflow
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output txd,
        output busy,
        output fifo_full,
        output fifo_empty,
        output overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered full/empty flags and occupancy count
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is still legal when the head leaves on the same edge
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign count_next = count + CW'(do_push) - CW'(do_pop);
    assign pop_data   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter, 8N1 LSB first
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);

    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam int            IW        = $clog2(UART_DATA_BITS);
    localparam logic [IW-1:0] BIT_LAST  = IW'(UART_DATA_BITS - 1);
    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
    end

    uart_state_e               state;
    uart_state_e               state_next;
    logic [BW-1:0]             baud_cnt;
    logic [BW-1:0]             baud_next;
    logic [IW-1:0]             bit_idx;
    logic [IW-1:0]             bit_next;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] shift_next;
`ifdef UART_TX_PARITY_EN
    logic                      parity_bit;
    logic                      parity_next;
`endif
    logic                      baud_last;
    logic                      pop;
    logic                      accept;
    logic                      overflow_q;
    logic                      txd_c;

    logic [UART_DATA_BITS-1:0] fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CW-1:0]             fifo_count;
    logic                      unused_wr_hi;

    assign unused_wr_hi = ^bus.wr_data[31:UART_DATA_BITS];

    assign accept = bus.wr_en && ((fifo_count < CW'(FIFO_DEPTH)) || pop);

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (bus.wr_data[UART_DATA_BITS-1:0]),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
            overflow_q <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_idx    <= bit_next;
            shift      <= shift_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
            if (bus.wr_en && !accept) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Popping in the last stop cycle starts the next frame with no idle gap
    always_comb begin
        state_next  = state;
        baud_next   = baud_cnt + 1'b1;
        bit_next    = bit_idx;
        shift_next  = shift;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif
        pop         = 1'b0;
        case (state)
            IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_next  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^fifo_rdata;
`endif
                    state_next  = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_next  = '0;
                    shift_next = shift >> 1;
                    if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_next  = '0;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        shift_next  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
                        parity_next = ^fifo_rdata;
`endif
                        state_next  = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                baud_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        txd_c = UART_IDLE_LEVEL;
        case (state)
            START:   txd_c = ~UART_IDLE_LEVEL;
            DATA:    txd_c = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_c = parity_bit;
`endif
            default: txd_c = UART_IDLE_LEVEL;
        endcase
    end

    assign bus.txd        = txd_c;
    assign bus.busy       = (state != IDLE) || !fifo_empty;
    assign bus.fifo_full  = fifo_full;
    assign bus.fifo_empty = fifo_empty;
    assign bus.overflow   = overflow_q;

endmodule
